// File: rtl/pwm_deadtime_gen_if.sv
// Gate-drive control bundle between the PWM source/config side and
// pwm_deadtime_gen. master = driver of raw PWM and config, slave = the
// dead-time generator.
interface pwm_deadtime_gen_if #(
  parameter int DT_W = 16
);
  logic            en;
  logic [DT_W-1:0] dt_rise;
  logic [DT_W-1:0] dt_fall;
  logic            pwm_in;
  logic            fault;
  logic            fault_clr;
  logic            pwm_h;
  logic            pwm_l;
  logic            fault_flag;
  logic            in_dead;

  modport master (
    output en, dt_rise, dt_fall, pwm_in, fault, fault_clr,
    input  pwm_h, pwm_l, fault_flag, in_dead
  );

  modport slave (
    input  en, dt_rise, dt_fall, pwm_in, fault, fault_clr,
    output pwm_h, pwm_l, fault_flag, in_dead
  );
endinterface

// File: rtl/pwm_deadtime_gen.sv
// Complementary high/low gate-drive generator with programmable dead time
// and a latched fault shutdown. Both outputs are registered and decoded from
// the next state, so pwm_h and pwm_l can never be high together.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   OFF   | disabled or just released from fault/reset, both outputs low
//   DEAD  | dead interval running towards level tgt, both outputs low
//   ON_H  | high side driven
//   ON_L  | low side driven
//   FAULT | latched shutdown, both low, waits for fault_clr with fault=0
module pwm_deadtime_gen #(
  parameter int DT_W = 16
) (
  input logic              clk,
  input logic              rst,
  pwm_deadtime_gen_if.slave bus
);

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_DEAD  = 3'd1,
    S_ON_H  = 3'd2,
    S_ON_L  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t          state, nxt_state;
  logic [DT_W-1:0] cnt, nxt_cnt;
  logic            tgt, nxt_tgt;
  logic            do_enter;
  logic [DT_W-1:0] dt_sel;

  // Next-state logic: fault beats disable beats normal sequencing. Entering a
  // dead interval always targets the current pwm_in level and samples dt then.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_tgt   = tgt;
    do_enter  = 1'b0;
    dt_sel    = bus.pwm_in ? bus.dt_rise : bus.dt_fall;

    if (bus.fault) begin
      nxt_state = S_FAULT;
    end else if (state == S_FAULT) begin
      if (bus.fault_clr) nxt_state = S_OFF;
    end else if (!bus.en) begin
      nxt_state = S_OFF;
    end else begin
      case (state)
        S_OFF:  do_enter = 1'b1;
        S_ON_H: do_enter = !bus.pwm_in;
        S_ON_L: do_enter = bus.pwm_in;
        S_DEAD: begin
          if (bus.pwm_in != tgt) begin
            do_enter = 1'b1;
          end else if (cnt == '0) begin
            nxt_state = tgt ? S_ON_H : S_ON_L;
          end else begin
            nxt_cnt = cnt - DT_W'(1);
          end
        end
        default: nxt_state = S_OFF;
      endcase

      if (do_enter) begin
        nxt_tgt = bus.pwm_in;
        if (dt_sel == '0) begin
          nxt_state = bus.pwm_in ? S_ON_H : S_ON_L;
        end else begin
          nxt_state = S_DEAD;
          nxt_cnt   = dt_sel - DT_W'(1);
        end
      end
    end
  end

  // State, counter and registered outputs decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_OFF;
      cnt            <= '0;
      tgt            <= 1'b0;
      bus.pwm_h      <= 1'b0;
      bus.pwm_l      <= 1'b0;
      bus.fault_flag <= 1'b0;
      bus.in_dead    <= 1'b0;
    end else begin
      state          <= nxt_state;
      cnt            <= nxt_cnt;
      tgt            <= nxt_tgt;
      bus.pwm_h      <= (nxt_state == S_ON_H);
      bus.pwm_l      <= (nxt_state == S_ON_L);
      bus.fault_flag <= (nxt_state == S_FAULT);
      bus.in_dead    <= (nxt_state == S_DEAD);
    end
  end

  // Shoot-through guard: the pair must never be driven high together.
  a_no_overlap: assert property (@(posedge clk) !(bus.pwm_h && bus.pwm_l));

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Scoreboard bench for pwm_deadtime_gen: a driver applies inputs on the
// falling edge and pushes the reference-model prediction; a monitor pops and
// compares just after every rising edge.
module tb_pwm_deadtime_gen;
  localparam int DT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pwm_deadtime_gen_if #(.DT_W(DT_W)) bus ();

  pwm_deadtime_gen #(.DT_W(DT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // current stimulus settings, applied every cycle by step()
  bit        c_rst = 1'b1;
  bit        c_en = 1'b0, c_pwm = 1'b0, c_fault = 1'b0, c_clr = 1'b0;
  logic [15:0] c_dr = '0, c_df = '0;

  // behavioural model: a gate pair is either idle, latched in fault, or
  // running towards level m_lvl with m_rem dead cycles still to wait
  bit m_fault, m_run, m_lvl;
  int m_rem;

  logic [3:0] exp_q[$];   // {h, l, fault_flag, in_dead}
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got h,l,flag,dead=%b expected %b", name, $time, got, exp);
    end
  endtask

  function automatic logic [3:0] m_out();
    bit on;
    on = m_run && (m_rem == 0);
    return {on && m_lvl, on && !m_lvl, m_fault, m_run && (m_rem > 0)};
  endfunction

  task automatic m_reset();
    m_fault = 0; m_run = 0; m_lvl = 0; m_rem = 0;
  endtask

  task automatic m_start(input bit lvl);
    m_lvl = lvl;
    m_rem = lvl ? int'(c_dr) : int'(c_df);
    m_run = 1;
  endtask

  task automatic m_clock();
    if (c_fault) begin
      m_fault = 1; m_run = 0;
    end else if (m_fault) begin
      if (c_clr) begin m_fault = 0; m_run = 0; end
    end else if (!c_en) begin
      m_run = 0;
    end else if (!m_run || (c_pwm != m_lvl)) begin
      m_start(c_pwm);
    end else if (m_rem > 0) begin
      m_rem--;
    end
  endtask

  task automatic apply();
    bus.en = c_en; bus.pwm_in = c_pwm; bus.fault = c_fault;
    bus.fault_clr = c_clr; bus.dt_rise = c_dr; bus.dt_fall = c_df;
  endtask

  task automatic step();
    @(negedge clk);
    rst = c_rst;
    apply();
    if (c_rst) m_reset(); else m_clock();
    exp_q.push_back(m_out());
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // reset asserted between edges; outputs must clear without a clock
  task automatic async_rst();
    @(negedge clk);
    apply();
    #2 rst = 1'b1;
    c_rst = 1'b1;
    m_reset();
    exp_q.push_back(m_out());
    #1 check("async_reset", {bus.pwm_h, bus.pwm_l, bus.fault_flag, bus.in_dead}, 4'b0000);
  endtask

  // monitor
  initial begin
    logic [3:0] exp;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        check("outputs", {bus.pwm_h, bus.pwm_l, bus.fault_flag, bus.in_dead}, exp);
        check("no_overlap", {2'b00, bus.pwm_h && bus.pwm_l, 1'b0}, 4'b0000);
      end
    end
  end

  // driver
  initial begin
    apply();
    m_reset();
    cyc(3);
    c_rst = 0;

    // 1: square wave with 3-cycle dead time both ways
    c_en = 1; c_dr = 3; c_df = 3;
    repeat (3) begin c_pwm = 1; cyc(20); c_pwm = 0; cyc(20); end

    // 2: zero dead time
    c_dr = 0; c_df = 0;
    repeat (3) begin c_pwm = 1; cyc(10); c_pwm = 0; cyc(10); end

    // 3: short high pulse swallowed, low side restarts its interval
    c_dr = 8; c_df = 8;
    c_pwm = 0; cyc(20);
    c_pwm = 1; cyc(5);
    c_pwm = 0; cyc(20);

    // 4: fault while ON_H, clear ignored while fault held, then recover
    c_pwm = 1; cyc(20);
    c_fault = 1; cyc(3);
    c_clr = 1; cyc(2);
    c_fault = 0; c_clr = 0; c_en = 0; cyc(3);
    c_en = 1; c_clr = 1; cyc(1);
    c_clr = 0; cyc(20);

    // enable drop and return
    c_en = 0; cyc(5);
    c_en = 1; cyc(15);

    // 5: maximum dead time, dt_rise changed mid-interval
    c_pwm = 0; cyc(20);
    c_dr = 16'hFFFF; c_pwm = 1; cyc(100);
    c_dr = 5; cyc(65535 - 100 + 10);

    // 6: async reset during DEAD and during ON_H
    c_dr = 10; c_df = 10;
    c_pwm = 0; cyc(30);
    c_pwm = 1; cyc(4);
    async_rst(); cyc(2);
    c_rst = 0; cyc(30);
    async_rst(); cyc(2);
    c_rst = 0; cyc(30);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) c_pwm = ~c_pwm;
      if ($urandom_range(0, 15) == 0) begin
        c_dr = 16'($urandom_range(0, 12));
        c_df = 16'($urandom_range(0, 12));
      end
      c_fault = ($urandom_range(0, 150) == 0);
      c_clr   = ($urandom_range(0, 8) == 0);
      c_en    = ($urandom_range(0, 60) != 0);
      step();
    end

    // drain the scoreboard
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
